// File: rtl/rx_ber_checker_if.sv
// Sample stream in, decision stream and BER statistics out.
interface rx_ber_checker_if #(
  parameter int unsigned NB_SAMPLE = 8,
  parameter int unsigned OVER_SAMP = 8,
  parameter int unsigned MAX_DELAY = 32
);
  localparam int unsigned PHASE_W = $clog2(OVER_SAMP);
  localparam int unsigned DLY_W   = $clog2(MAX_DELAY);

  logic                        i_enable;
  logic                        i_valid;
  logic signed [NB_SAMPLE-1:0] i_sample;
  logic [PHASE_W-1:0]          i_phase;
  logic                        i_ref_bit;
  logic                        o_bit;
  logic                        o_bit_valid;
  logic                        o_locked;
  logic [DLY_W-1:0]            o_best_delay;
  logic [31:0]                 o_err_count;
  logic [31:0]                 o_bit_count;

  modport master (
    output i_enable, i_valid, i_sample, i_phase, i_ref_bit,
    input  o_bit, o_bit_valid, o_locked, o_best_delay, o_err_count, o_bit_count
  );

  modport slave (
    input  i_enable, i_valid, i_sample, i_phase, i_ref_bit,
    output o_bit, o_bit_valid, o_locked, o_best_delay, o_err_count, o_bit_count
  );
endinterface

// File: rtl/rx_ber_checker.sv
// Symbol decimator, slicer and PRBS alignment search / BER counter.
module rx_ber_checker #(
  parameter int unsigned NB_SAMPLE = 8,
  parameter int unsigned OVER_SAMP = 8,
  parameter int unsigned MAX_DELAY = 32,
  parameter int unsigned WINDOW    = 128
) (
  input  logic             clk,
  input  logic             rst,
  rx_ber_checker_if.slave  bus
);

  localparam int unsigned PHASE_W = $clog2(OVER_SAMP);
  localparam int unsigned DLY_W   = $clog2(MAX_DELAY);
  localparam int unsigned HIST_W  = MAX_DELAY - 1;
  localparam int unsigned WCNT_W  = $clog2(WINDOW);
  localparam int unsigned WERR_W  = $clog2(WINDOW) + 1;

  localparam logic [WCNT_W-1:0] WIN_LAST  = WCNT_W'(WINDOW - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(MAX_DELAY - 1);
  localparam logic [WERR_W-1:0] ERR_LIMIT = WERR_W'(WINDOW / 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCK   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [DLY_W-1:0]    best_q, best_d;
  logic [WCNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]   win_err_q, win_err_d;
  logic [WERR_W-1:0]   min_err_q, min_err_d;
  logic                bit_q, bit_d;
  logic                bit_valid_q, bit_valid_d;
  logic                locked_q, locked_d;
  logic [DLY_W-1:0]    best_delay_q, best_delay_d;
  logic [31:0]         err_cnt_q, err_cnt_d;
  logic [31:0]         bit_cnt_q, bit_cnt_d;

  logic                strobe_c;
  logic                decision_c;
  logic [MAX_DELAY-1:0] ref_vec_c;
  logic                err_bit_c;
  logic [WERR_W-1:0]   win_err_sum_c;
  logic                win_end_c;
  logic                new_min_c;
  logic                enter_search_c;

  // Symbol strobe, slicer and per-strobe mismatch against the selected delay.
  always_comb begin
    strobe_c      = bus.i_enable & bus.i_valid & (phase_q == bus.i_phase);
    decision_c    = (bus.i_sample < NB_SAMPLE'(0));
    ref_vec_c     = {hist_q, bus.i_ref_bit};
    err_bit_c     = decision_c ^ ((state_q == LOCK) ? ref_vec_c[best_delay_q]
                                                    : ref_vec_c[dly_q]);
    win_err_sum_c = win_err_q + WERR_W'(err_bit_c);
    win_end_c     = strobe_c & (win_cnt_q == WIN_LAST);
    new_min_c     = (win_err_sum_c < min_err_q);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    hist_d         = hist_q;
    dly_d          = dly_q;
    best_d         = best_q;
    win_cnt_d      = win_cnt_q;
    win_err_d      = win_err_q;
    min_err_d      = min_err_q;
    bit_d          = bit_q;
    bit_valid_d    = 1'b0;
    best_delay_d   = best_delay_q;
    err_cnt_d      = err_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    enter_search_c = 1'b0;

    if (bus.i_enable && bus.i_valid) begin
      phase_d = phase_q + PHASE_W'(1);
    end

    if (strobe_c) begin
      bit_d       = decision_c;
      bit_valid_d = 1'b1;
      hist_d      = ref_vec_c[HIST_W-1:0];
    end

    unique case (state_q)
      IDLE: begin
        if (bus.i_enable) begin
          state_d        = SEARCH;
          enter_search_c = 1'b1;
        end
      end
      SEARCH: begin
        if (!bus.i_enable) begin
          state_d = IDLE;
        end else if (strobe_c) begin
          win_cnt_d = win_cnt_q + WCNT_W'(1);
          win_err_d = win_err_sum_c;
          if (win_end_c) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (new_min_c) begin
              min_err_d = win_err_sum_c;
              best_d    = dly_q;
            end
            if (dly_q == DLY_LAST) begin
              state_d      = LOCK;
              best_delay_d = new_min_c ? dly_q : best_q;
            end else begin
              dly_d = dly_q + DLY_W'(1);
            end
          end
        end
      end
      LOCK: begin
        if (!bus.i_enable) begin
          state_d = IDLE;
        end else if (strobe_c) begin
          bit_cnt_d = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + 32'd1;
          if (err_bit_c) begin
            err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 32'd1;
          end
          win_cnt_d = win_cnt_q + WCNT_W'(1);
          win_err_d = win_err_sum_c;
          if (win_end_c) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_sum_c > ERR_LIMIT) begin
              state_d        = SEARCH;
              enter_search_c = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh search always starts from candidate 0 with empty statistics.
    if (enter_search_c) begin
      dly_d     = '0;
      win_cnt_d = '0;
      win_err_d = '0;
      err_cnt_d = '0;
      bit_cnt_d = '0;
      min_err_d = '1;
    end

    locked_d = (state_d == LOCK);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      hist_q       <= '0;
      dly_q        <= '0;
      best_q       <= '0;
      win_cnt_q    <= '0;
      win_err_q    <= '0;
      min_err_q    <= '1;
      bit_q        <= 1'b0;
      bit_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      best_delay_q <= '0;
      err_cnt_q    <= '0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hist_q       <= hist_d;
      dly_q        <= dly_d;
      best_q       <= best_d;
      win_cnt_q    <= win_cnt_d;
      win_err_q    <= win_err_d;
      min_err_q    <= min_err_d;
      bit_q        <= bit_d;
      bit_valid_q  <= bit_valid_d;
      locked_q     <= locked_d;
      best_delay_q <= best_delay_d;
      err_cnt_q    <= err_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign bus.o_bit        = bit_q;
  assign bus.o_bit_valid  = bit_valid_q;
  assign bus.o_locked     = locked_q;
  assign bus.o_best_delay = best_delay_q;
  assign bus.o_err_count  = err_cnt_q;
  assign bus.o_bit_count  = bit_cnt_q;

endmodule

// File: tb/tb_rx_ber_checker.sv
// Directed bench: decimation table on an 8x instance, alignment/BER/relock/
// saturation/reset sequences on a 2x instance (keeps the run short).
module tb_rx_ber_checker;

  logic clk;
  logic rst_n;

  rx_ber_checker_if #(.NB_SAMPLE(8), .OVER_SAMP(8), .MAX_DELAY(32)) bus8 ();
  rx_ber_checker_if #(.NB_SAMPLE(8), .OVER_SAMP(2), .MAX_DELAY(32)) bus2 ();

  rx_ber_checker #(.NB_SAMPLE(8), .OVER_SAMP(8), .MAX_DELAY(32), .WINDOW(128)) dut8 (
    .clk (clk),
    .rst (rst_n),
    .bus (bus8)
  );

  rx_ber_checker #(.NB_SAMPLE(8), .OVER_SAMP(2), .MAX_DELAY(32), .WINDOW(128)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic              en;
    logic              vld;
    logic [2:0]        ph;
    logic signed [7:0] smp;
    logic              ebv;
    logic              eb;
  } vec_t;

  vec_t tv [22];

  logic [14:0] lfsr = 15'h1ACE;
  bit          rh [64];
  int          cur_delay = 5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One symbol on the 2x instance: strobe on the first sample (i_phase=0).
  task automatic sym(input bit flip);
    bit r;
    bit data;
    r    = lfsr[14] ^ lfsr[13];
    lfsr = {lfsr[13:0], r};
    for (int k = 63; k > 0; k--) rh[k] = rh[k-1];
    rh[0] = r;
    data  = rh[cur_delay] ^ flip;
    bus2.i_valid   = 1'b1;
    bus2.i_ref_bit = r;
    bus2.i_sample  = data ? -8'sd64 : 8'sd64;
    @(posedge clk); #1;
    bus2.i_valid   = 1'b1;
    @(posedge clk); #1;
    bus2.i_valid   = 1'b0;
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 64; k++) rh[k] = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b1, 3'd3, -8'sd8,   1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 3'd3, -8'sd7,   1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 3'd3, -8'sd6,   1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 3'd3, -8'sd5,   1'b1, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 3'd3, -8'sd100, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 3'd3, -8'sd4,   1'b0, 1'b1};
    tv[6]  = '{1'b1, 1'b1, 3'd3, -8'sd3,   1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b1, 3'd3, -8'sd2,   1'b0, 1'b1};
    tv[8]  = '{1'b1, 1'b1, 3'd3, -8'sd1,   1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b1, 3'd3, 8'sd0,    1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b1, 3'd3, 8'sd1,    1'b0, 1'b1};
    tv[11] = '{1'b1, 1'b1, 3'd3, 8'sd2,    1'b0, 1'b1};
    tv[12] = '{1'b1, 1'b1, 3'd3, 8'sd3,    1'b1, 1'b0};
    tv[13] = '{1'b1, 1'b1, 3'd3, 8'sd4,    1'b0, 1'b0};
    tv[14] = '{1'b1, 1'b1, 3'd3, 8'sd5,    1'b0, 1'b0};
    tv[15] = '{1'b1, 1'b1, 3'd3, 8'sd6,    1'b0, 1'b0};
    tv[16] = '{1'b1, 1'b1, 3'd3, 8'sd7,    1'b0, 1'b0};
    tv[17] = '{1'b1, 1'b1, 3'd0, -8'sd1,   1'b1, 1'b1};
    tv[18] = '{1'b1, 1'b1, 3'd2, 8'sd0,    1'b0, 1'b1};
    tv[19] = '{1'b1, 1'b1, 3'd2, 8'sd0,    1'b1, 1'b0};
    tv[20] = '{1'b0, 1'b1, 3'd3, -8'sd1,   1'b0, 1'b0};
    tv[21] = '{1'b1, 1'b1, 3'd3, -8'sd2,   1'b1, 1'b1};

    clear_hist();
    rst_n = 1'b0;
    bus8.i_enable = 1'b0; bus8.i_valid = 1'b0; bus8.i_sample = '0;
    bus8.i_phase = '0; bus8.i_ref_bit = 1'b0;
    bus2.i_enable = 1'b0; bus2.i_valid = 1'b0; bus2.i_sample = '0;
    bus2.i_phase = '0; bus2.i_ref_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bit",        32'(bus2.o_bit), 32'd0);
    chk("rst_bit_valid",  32'(bus2.o_bit_valid), 32'd0);
    chk("rst_locked",     32'(bus2.o_locked), 32'd0);
    chk("rst_best_delay", 32'(bus2.o_best_delay), 32'd0);
    chk("rst_err_count",  bus2.o_err_count, 32'd0);
    chk("rst_bit_count",  bus2.o_bit_count, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decimation table on the 8x instance.
    for (int i = 0; i < 22; i++) begin
      bus8.i_enable = tv[i].en;
      bus8.i_valid  = tv[i].vld;
      bus8.i_phase  = tv[i].ph;
      bus8.i_sample = tv[i].smp;
      @(posedge clk); #1;
      chk($sformatf("dec_bv[%0d]", i), 32'(bus8.o_bit_valid), 32'(tv[i].ebv));
      chk($sformatf("dec_bit[%0d]", i), 32'(bus8.o_bit), 32'(tv[i].eb));
    end
    bus8.i_enable = 1'b0;
    bus8.i_valid  = 1'b0;

    // Alignment search with the reference delayed by 5 symbols.
    cur_delay = 5;
    bus2.i_enable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32*128 - 1; i++) sym(1'b0);
    chk("align_not_yet_locked", 32'(bus2.o_locked), 32'd0);
    sym(1'b0);
    chk("align_locked",     32'(bus2.o_locked), 32'd1);
    chk("align_best_delay", 32'(bus2.o_best_delay), 32'd5);
    chk("align_err_count",  bus2.o_err_count, 32'd0);
    chk("align_bit_count",  bus2.o_bit_count, 32'd0);

    // BER: one flipped decision per 100 symbols.
    for (int i = 0; i < 10000; i++) begin
      sym((i % 100) == 99);
      if (i == 0) chk("ber_first_count", bus2.o_bit_count, 32'd1);
    end
    chk("ber_bit_count", bus2.o_bit_count, 32'd10000);
    chk("ber_err_count", bus2.o_err_count, 32'd100);
    chk("ber_locked",    32'(bus2.o_locked), 32'd1);

    // Error counter saturation.
    force dut.err_cnt_q = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    release dut.err_cnt_q;
    sym(1'b1);
    chk("sat_step", bus2.o_err_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) sym(1'b1);
    chk("sat_hold",      bus2.o_err_count, 32'hFFFF_FFFF);
    chk("sat_bit_count", bus2.o_bit_count, 32'd10005);

    // Relock after the reference delay moves to 9.
    cur_delay = 9;
    for (int i = 0; i < 300; i++) begin
      sym(1'b0);
      if (!bus2.o_locked) break;
    end
    chk("relock_drop",      32'(bus2.o_locked), 32'd0);
    chk("relock_err_clear", bus2.o_err_count, 32'd0);
    chk("relock_bit_clear", bus2.o_bit_count, 32'd0);
    for (int i = 0; i < 32*128; i++) sym(1'b0);
    chk("relock_locked",     32'(bus2.o_locked), 32'd1);
    chk("relock_best_delay", 32'(bus2.o_best_delay), 32'd9);

    // Enable dropped while locked.
    for (int i = 0; i < 10; i++) sym(i == 2 || i == 5 || i == 7);
    chk("pre_dis_bits", bus2.o_bit_count, 32'd10);
    chk("pre_dis_errs", bus2.o_err_count, 32'd3);
    bus2.i_enable = 1'b0;
    bus2.i_valid  = 1'b1;
    bus2.i_sample = -8'sd64;
    @(posedge clk); #1;
    chk("dis_locked", 32'(bus2.o_locked), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("dis_bit_valid",  32'(bus2.o_bit_valid), 32'd0);
    chk("dis_bit_count",  bus2.o_bit_count, 32'd10);
    chk("dis_err_count",  bus2.o_err_count, 32'd3);
    chk("dis_best_delay", 32'(bus2.o_best_delay), 32'd9);
    bus2.i_valid  = 1'b0;
    bus2.i_enable = 1'b1;
    @(posedge clk); #1;
    chk("reen_bit_clear", bus2.o_bit_count, 32'd0);
    for (int i = 0; i < 50; i++) sym(1'b0);

    // Asynchronous reset in the middle of a search.
    bus2.i_valid   = 1'b1;
    bus2.i_sample  = -8'sd64;
    bus2.i_ref_bit = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_bit_valid", 32'(bus2.o_bit_valid), 32'd1);
    chk("pre_rst_bit",       32'(bus2.o_bit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bit",        32'(bus2.o_bit), 32'd0);
    chk("arst_bit_valid",  32'(bus2.o_bit_valid), 32'd0);
    chk("arst_locked",     32'(bus2.o_locked), 32'd0);
    chk("arst_best_delay", 32'(bus2.o_best_delay), 32'd0);
    chk("arst_err_count",  bus2.o_err_count, 32'd0);
    chk("arst_bit_count",  bus2.o_bit_count, 32'd0);
    bus2.i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_hist();
    @(posedge clk); #1;
    for (int i = 0; i < 32*128 - 1; i++) sym(1'b0);
    chk("restart_not_yet_locked", 32'(bus2.o_locked), 32'd0);
    sym(1'b0);
    chk("restart_locked",     32'(bus2.o_locked), 32'd1);
    chk("restart_best_delay", 32'(bus2.o_best_delay), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_ber_checker.md
RX_BER_CHECKER -- requirements
Module: rx_ber_checker

Interface
REQ-001 Parameters (name, default, meaning):
- NB_SAMPLE, 8, signed sample width.
- OVER_SAMP, 8, samples per symbol (power of 2).
- MAX_DELAY, 32, reference alignment candidates (power of 2).
- WINDOW, 128, symbols per measurement window.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, reset, asynchronous, active-low.
- i_enable, in, 1, block enable.
- i_valid, in, 1, one oversampled sample present.
- i_sample, in, NB_SAMPLE, signed filtered sample.
- i_phase, in, log2(OVER_SAMP), sampling phase select.
- i_ref_bit, in, 1, local reference PRBS bit.
- o_bit, out, 1, sliced symbol decision.
- o_bit_valid, out, 1, one-cycle decision strobe.
- o_locked, out, 1, high in LOCK state.
- o_best_delay, out, log2(MAX_DELAY), selected alignment.
- o_err_count, out, 32, errors counted in LOCK.
- o_bit_count, out, 32, bits compared in LOCK.

Function
REQ-003 The phase counter SHALL increment modulo OVER_SAMP on each cycle with i_valid=1 and i_enable=1, and SHALL hold otherwise.
REQ-004 The symbol strobe SHALL be asserted in a cycle when i_valid=1, i_enable=1 and the phase counter equals i_phase; a change to i_phase SHALL take effect on the next qualifying cycle, without resynchronisation.
REQ-005 The decision SHALL be the sign bit of i_sample: negative gives 1, zero or positive gives 0.
REQ-006 o_bit SHALL be registered; o_bit and o_bit_valid SHALL appear 1 cycle after the strobe, and o_bit_valid SHALL be high for exactly 1 cycle.
REQ-007 On each strobe, i_ref_bit SHALL be shifted into a MAX_DELAY-1 deep history register.
REQ-008 Candidate delay d SHALL compare the decision against:
- the current i_ref_bit when d=0;
- the reference bit from d strobes earlier when d>0.
An error SHALL be a mismatch.
REQ-009 The FSM SHALL have the states IDLE, SEARCH and LOCK.
REQ-010 IDLE -> SEARCH on i_enable=1. Entry to SEARCH SHALL:
- clear d, the window counter, the window error count, o_err_count and o_bit_count;
- set min_err to all-ones.
REQ-011 In SEARCH, each candidate d SHALL be measured over WINDOW strobes. At the window end:
- if the window errors are strictly less than min_err, min_err SHALL be updated and best=d (on ties the lowest d is kept);
- d SHALL then increment.
REQ-012 At the end of the window for d=MAX_DELAY-1, the FSM SHALL go to LOCK with o_best_delay=best.
REQ-013 In LOCK, each strobe SHALL increment o_bit_count and SHALL increment o_err_count on a mismatch at o_best_delay; updates SHALL be visible 1 cycle after the strobe.
REQ-014 Both counters SHALL saturate at 2^32-1 and SHALL not wrap.
REQ-015 In LOCK, per-WINDOW error counting SHALL continue; a window with more than WINDOW/4 errors SHALL cause a transition to SEARCH, which applies the REQ-010 entry actions.
REQ-016 i_enable=0 in any state SHALL force IDLE on the next edge:
- no strobes are generated;
- the phase counter, o_err_count, o_bit_count and o_best_delay hold;
- o_locked=0.
REQ-017 The window-end decision and the counting of that window's final strobe SHALL occur in the same cycle; the final strobe SHALL be included in that window.

Reset
REQ-018 When rst=0, regardless of clk, the block SHALL asynchronously force:
- state IDLE and phase counter 0;
- the history register, d, best and the window counters cleared;
- min_err all-ones;
- o_bit=0, o_bit_valid=0, o_locked=0, o_best_delay=0, o_err_count=0, o_bit_count=0.
REQ-019 Reset asserted mid-SEARCH or mid-LOCK SHALL discard all progress; after release with i_enable=1, the search SHALL restart at d=0.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Decimation: OVER_SAMP=8, i_phase=3, i_valid every cycle, a ramp -8..+7 -> a strobe on every 8th valid starting at the 4th; o_bit_valid 1 cycle later; o_bit=1 only for negative values.
- Alignment: decisions equal to the reference delayed 5 symbols, no errors -> after 32x128 strobes o_locked=1, o_best_delay=5, o_err_count=0.
- BER: locked at d=5, 1 bit flipped every 100 symbols, 10000 symbols -> o_bit_count=10000, o_err_count=100.
- Relock: locked, then the reference delay changes to 9 -> the window exceeds 32 errors, SEARCH runs, relock with o_best_delay=9.
- Saturation: o_err_count preloaded near max via force, continuous errors -> holds at 0xFFFFFFFF.
- Reset/enable: rst=0 mid-SEARCH -> all outputs 0 immediately; i_enable=0 in LOCK -> counters hold, o_locked=0.
